// File: rtl/dmem_port_arb.sv
// rtl/dmem_port_arb.sv - CPU/debug arbiter for a single data-memory RAM port
module dmem_port_arb #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_gnt,
    output logic                    cpu_stall,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,

    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic                    dbg_burst,
    input  logic                    dbg_last,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_wstrb,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,

    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam int BEAT_WIDTH   = $clog2(BURST_MAX + 1);

    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
    // beat_cnt counts beats already transferred, so the beat granted while
    // beat_cnt holds BURST_MAX-1 is the final one a burst may take
    localparam logic [BEAT_WIDTH-1:0]   BEAT_LAST  = BEAT_WIDTH'(BURST_MAX - 1);

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DBG = 1'b1
    } state_t;

    state_t                  state;
    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic [BEAT_WIDTH-1:0]   beat_cnt;
    logic                    starved;
    logic                    burst_done;

    // read tracking: index 0 is one cycle after the command, index 1 is two
    logic [1:0]              rd_valid;
    logic [1:0]              rd_owner;

    assign starved    = dbg_req && (starve_cnt == STARVE_MAX);
    assign burst_done = dbg_last || (beat_cnt == BEAT_LAST);

    // combinational grants from the current state and the live requests
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (rst) begin
            if (state == ARB_CPU) begin
                if (cpu_req && !starved) begin
                    cpu_gnt = 1'b1;
                end else if (dbg_req) begin
                    dbg_gnt = 1'b1;
                end
            end else begin
                dbg_gnt = dbg_req;
            end
            cpu_stall = cpu_req && !cpu_gnt;
        end
    end

    // RAM command mux from the granted requester; all zero when idle
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (cpu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_wstrb = cpu_wstrb;
        end else if (dbg_gnt) begin
            ram_en    = 1'b1;
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_wstrb = dbg_wstrb;
        end
    end

    // arbitration FSM: debug burst ownership and beat counting
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ARB_CPU;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_CPU: begin
                    if (dbg_gnt && dbg_burst && !dbg_last) begin
                        state    <= ARB_DBG;
                        beat_cnt <= BEAT_WIDTH'(1);
                    end
                end
                ARB_DBG: begin
                    if (dbg_gnt) begin
                        if (burst_done) begin
                            state    <= ARB_CPU;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state    <= ARB_CPU;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // debug starvation counter, saturating at the forced-grant threshold
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (dbg_req && !dbg_gnt) begin
            if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // two-deep read tracker; reset drops any reads still in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= '0;
            rd_owner <= '0;
        end else begin
            rd_valid <= {rd_valid[0], ram_en && !ram_we};
            rd_owner <= {rd_owner[0], dbg_gnt};
        end
    end

    // route the returning RAM data to the owner of the stage-2 entry
    always_comb begin
        cpu_rvalid = rst && rd_valid[1] && !rd_owner[1];
        dbg_rvalid = rst && rd_valid[1] &&  rd_owner[1];
        cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
        dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
    end

    logic unused_strb;
    assign unused_strb = (STRB_WIDTH == 0);

endmodule
